key_entry_accumulator: RTL and testbench
========================================

Name: key_entry_accumulator

Overview:
- Sits directly downstream of the keypad encoder and consumes its keycode/keystrobe pair.
- Assembles decimal digit keystrokes into a BCD entry buffer and supports backspace and clear.
- On enter, serially converts the buffer to an unsigned binary operand.
- Presents the operand to the matrix datapath with a valid/ready handshake.

Parameters:
- MAX_DIGITS, 4, maximum digits held in the entry buffer.
- VALUE_W, 14, output operand width; must satisfy 10^MAX_DIGITS-1 < 2^VALUE_W.
- TIMEOUT_CYCLES, 50000000, idle cycles before auto-clear (used only with the optional feature).

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- keycode  in  4  key code from encoder; meaningful only when keystrobe=1.
- keystrobe  in  1  single-cycle key-press pulse.
- out_ready  in  1  consumer accepts operand.
- out_value  out  VALUE_W  converted operand.
- out_valid  out  1  operand valid.
- entry_bcd  out  4*MAX_DIGITS  live buffer for display; digit 0 is the LS nibble.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently held.
- busy  out  1  high in CONVERT or HOLD.

Behaviour:
- Reset values: out_value=0, out_valid=0, entry_bcd=0, digit_count=0, busy=0, state=ENTRY.
- Keycode map: 0-9 are digits, 10=BKSP, 11=ENTER, 12=CLEAR. 13-15 (15 means multi-key) are ignored. Keycode is sampled only when keystrobe=1.
- State ENTRY, per keystrobe:
  - digit with digit_count<MAX_DIGITS: entry_bcd<={entry_bcd[4*MAX_DIGITS-5:0],keycode}, digit_count+1.
  - digit with buffer full: ignored.
  - BKSP with digit_count>0: shift right one nibble with zero fill, digit_count-1. With an empty buffer it is a no-op.
  - CLEAR: entry_bcd=0, digit_count=0.
  - ENTER with digit_count>0: go to CONVERT. Set acc=0 and idx=digit_count-1.
  - ENTER with an empty buffer: ignored.
- State CONVERT, one digit per clock:
  - acc<=(acc<<3)+(acc<<1)+entry_bcd[4*idx+:4]; arithmetic is in VALUE_W bits and cannot overflow given the parameter constraint.
  - On the edge processing idx=0: out_value<=result, out_valid<=1, go to HOLD.
  - Latency: out_valid rises exactly digit_count edges after the edge that samples ENTER.
- State HOLD:
  - out_value and out_valid are held stable until out_ready=1.
  - On the edge with out_valid&&out_ready: out_valid<=0, entry_bcd<=0, digit_count<=0, go to ENTRY.
  - out_ready may already be high when valid rises; acceptance then occurs on the next edge.
- All keystrobes in CONVERT or HOLD are dropped, including CLEAR. entry_bcd stays frozen and visible there.
- out_ready is ignored outside HOLD.
- nrst low in any state immediately returns all outputs and state to reset values; a partial conversion is discarded.

Optional Feature:
- Macro: KEY_ENTRY_TIMEOUT_EN.
- When defined:
  - An idle counter runs in ENTRY while digit_count>0.
  - It is reset by any accepted or ignored keystrobe.
  - On reaching TIMEOUT_CYCLES-1 it clears the buffer exactly as CLEAR does, and the counter returns to 0.
  - The counter is held at 0 outside ENTRY.
- When undefined: no counter exists, the buffer persists indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package keypad_pkg:
  - keycode constants KEY_BKSP=4'd10, KEY_ENTER=4'd11, KEY_CLEAR=4'd12, KEY_INVALID=4'd15.
  - typedef entry_state_t {ENTRY, CONVERT, HOLD}.
  - The package is shared with the encoder and the consumer.
- One natural sub-module, entry_digit_buffer: the BCD shift register plus digit counter, with push/pop/clear controls and a full/empty indication.
- The FSM and the mult-by-10 accumulator remain in the top module.

Test Plan:
- Keys 1,2,3,4,ENTER with out_ready=1 -> out_valid rises 4 edges after ENTER; out_value=1234 (0x4D2); buffer clears after the handshake.
- Keys 9,9,9,9,7,ENTER -> digit 7 is ignored; out_value=9999; digit_count=4 before ENTER.
- Keys 5,6,BKSP,BKSP,BKSP,8,ENTER -> extra BKSP is a no-op; out_value=8 after 1 edge. ENTER on an empty buffer -> no out_valid.
- Keys 4,2,ENTER with out_ready=0 for 20 cycles, plus keys 7 and CLEAR pressed meanwhile -> out_value=42 held stable; keys dropped; buffer cleared only on acceptance.
- Keys 3,1,4,ENTER, then nrst pulsed low during the 2nd CONVERT cycle -> all outputs 0; state ENTRY; later entry 7,ENTER yields 7.
- With KEY_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: key 6, then 16 idle cycles -> digit_count=0, entry_bcd=0. Without the macro the buffer is retained.

Source files
------------

// File: rtl/keypad_pkg.sv
// Keypad keycodes and entry-accumulator types shared by the encoder, the
// key_entry_accumulator and the operand consumer.
package keypad_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [3:0] KEY_BKSP    = 4'd10;
   localparam logic [3:0] KEY_ENTER   = 4'd11;
   localparam logic [3:0] KEY_CLEAR   = 4'd12;
   localparam logic [3:0] KEY_INVALID = 4'd15;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      CONVERT = 2'd1,
      HOLD    = 2'd2
   } entry_state_t;

   // Codes 0-9 are decimal digits
   function automatic logic is_digit(input logic [3:0] code);
      return code < 4'd10;
   endfunction

endpackage

// File: rtl/entry_digit_buffer.sv
// BCD entry shift register with digit counter: push shifts a digit in at the
// LS nibble, pop drops the LS nibble, clear empties; clear wins over push/pop.
module entry_digit_buffer
   import keypad_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = 4
) (
   input  logic                                 clk,
   input  logic                                 nrst,
   input  logic                                 push_i,
   input  logic                                 pop_i,
   input  logic                                 clr_i,
   input  logic [DIGIT_W-1:0]                   digit_i,
   output logic [DIGIT_W*MAX_DIGITS-1:0]        bcd_o,
   output logic [$clog2(MAX_DIGITS+1)-1:0]      count_o,
   output logic                                 full_o_c,
   output logic                                 empty_o_c
);

   localparam int unsigned BcdW = DIGIT_W * MAX_DIGITS;
   localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

   logic [BcdW-1:0] bcd_q, bcd_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign full_o_c  = (cnt_q == CntW'(MAX_DIGITS));
   assign empty_o_c = (cnt_q == '0);

   always_comb begin
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         bcd_d = '0;
         cnt_d = '0;
      end else if (push_i && !full_o_c) begin
         bcd_d = {bcd_q[BcdW-DIGIT_W-1:0], digit_i};
         cnt_d = cnt_q + CntW'(1);
      end else if (pop_i && !empty_o_c) begin
         bcd_d = {DIGIT_W'(0), bcd_q[BcdW-1:DIGIT_W]};
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign bcd_o   = bcd_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/key_entry_accumulator.sv
// Collects keypad digits into a BCD buffer, converts it MS digit first to
// binary on ENTER and offers the operand on a valid/ready handshake.
// Optional idle auto-clear: define KEY_ENTRY_TIMEOUT_EN.
module key_entry_accumulator
   import keypad_pkg::*;
#(
   parameter int unsigned MAX_DIGITS     = 4,
   parameter int unsigned VALUE_W        = 14,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic                                 clk,
   input  logic                                 nrst,
   input  logic [3:0]                           keycode,
   input  logic                                 keystrobe,
   input  logic                                 out_ready,
   output logic [VALUE_W-1:0]                   out_value,
   output logic                                 out_valid,
   output logic [DIGIT_W*MAX_DIGITS-1:0]        entry_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count,
   output logic                                 busy
);

   localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
   localparam int unsigned IdxW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

   // Elaboration-time guard on the parameter set
   if ((10 ** MAX_DIGITS) > (2 ** VALUE_W) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("key_entry_accumulator: invalid MAX_DIGITS/VALUE_W/TIMEOUT_CYCLES");
   end

   entry_state_t        state_q, state_d;
   logic [VALUE_W-1:0]  acc_q, acc_d, acc_next;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [VALUE_W-1:0]  out_value_q, out_value_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                push, pop, clr;
   logic                full_c, empty_c, timeout_c;
   logic [DIGIT_W-1:0]  cur_digit;

   entry_digit_buffer #(
      .MAX_DIGITS (MAX_DIGITS)
   ) u_buf (
      .clk       (clk),
      .nrst      (nrst),
      .push_i    (push),
      .pop_i     (pop),
      .clr_i     (clr),
      .digit_i   (keycode),
      .bcd_o     (entry_bcd),
      .count_o   (digit_count),
      .full_o_c  (full_c),
      .empty_o_c (empty_c)
   );

`ifdef KEY_ENTRY_TIMEOUT_EN
   localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES);

   logic [IdleW-1:0] idle_q, idle_d;

   // Idle counter only runs while a partial entry is waiting in ENTRY
   always_comb begin
      idle_d    = '0;
      timeout_c = 1'b0;
      if (state_q == ENTRY && !empty_c && !keystrobe) begin
         if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) timeout_c = 1'b1;
         else                                       idle_d    = idle_q + IdleW'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`else
   assign timeout_c = 1'b0;
`endif

   assign cur_digit = entry_bcd[DIGIT_W*idx_q +: DIGIT_W];
   assign acc_next  = (acc_q << 3) + (acc_q << 1) + VALUE_W'(cur_digit);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_value_d = out_value_q;
      out_valid_d = out_valid_q;
      push        = 1'b0;
      pop         = 1'b0;
      clr         = 1'b0;
      unique case (state_q)
         ENTRY: begin
            if (keystrobe) begin
               if (is_digit(keycode))       push = 1'b1;
               else if (keycode == KEY_BKSP)  pop  = 1'b1;
               else if (keycode == KEY_CLEAR) clr  = 1'b1;
               else if (keycode == KEY_ENTER && !empty_c) begin
                  state_d = CONVERT;
                  acc_d   = '0;
                  idx_d   = IdxW'(digit_count - CntW'(1));
               end
            end else if (timeout_c) begin
               clr = 1'b1;
            end
         end
         CONVERT: begin
            acc_d = acc_next;
            if (idx_q == '0) begin
               out_value_d = acc_next;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               idx_d = idx_q - IdxW'(1);
            end
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               clr         = 1'b1;
               state_d     = ENTRY;
            end
         end
         default: state_d = ENTRY;
      endcase
      busy_d = (state_d != ENTRY);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ENTRY;
         acc_q       <= '0;
         idx_q       <= '0;
         out_value_q <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_value_q <= out_value_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign out_value = out_value_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_key_entry_accumulator.sv
// Directed self-checking bench for key_entry_accumulator (TIMEOUT_CYCLES=16).
module tb_key_entry_accumulator;
   import keypad_pkg::*;

   localparam int unsigned MAX_DIGITS = 4;
   localparam int unsigned VALUE_W    = 14;
   localparam int unsigned CntW       = $clog2(MAX_DIGITS + 1);

   logic                       clk = 1'b0;
   logic                       nrst;
   logic [3:0]                 keycode;
   logic                       keystrobe;
   logic                       out_ready;
   logic [VALUE_W-1:0]         out_value;
   logic                       out_valid;
   logic [4*MAX_DIGITS-1:0]    entry_bcd;
   logic [CntW-1:0]            digit_count;
   logic                       busy;

   int n_checks = 0;
   int n_fail   = 0;

   key_entry_accumulator #(
      .MAX_DIGITS     (MAX_DIGITS),
      .VALUE_W        (VALUE_W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .keycode     (keycode),
      .keystrobe   (keystrobe),
      .out_ready   (out_ready),
      .out_value   (out_value),
      .out_valid   (out_valid),
      .entry_bcd   (entry_bcd),
      .digit_count (digit_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] k);
      keycode   = k;
      keystrobe = 1'b1;
      tick(1);
      keystrobe = 1'b0;
      keycode   = 4'd0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".value"}, 32'(out_value), 32'd0);
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".bcd"},   32'(entry_bcd), 32'd0);
      chk({tag, ".count"}, 32'(digit_count), 32'd0);
      chk({tag, ".busy"},  32'(busy), 32'd0);
   endtask

   initial begin
      nrst      = 1'b0;
      keycode   = 4'd0;
      keystrobe = 1'b0;
      out_ready = 1'b0;
      tick(3);
      chk_idle("reset");
      nrst = 1'b1;
      tick(1);

      // 1,2,3,4,ENTER with ready high
      out_ready = 1'b1;
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      chk("t1.bcd",   32'(entry_bcd), 32'h1234);
      chk("t1.count", 32'(digit_count), 32'd4);
      press(KEY_ENTER);
      chk("t1.busy",  32'(busy), 32'd1);
      tick(3);
      chk("t1.valid_early", 32'(out_valid), 32'd0);
      tick(1);
      chk("t1.valid", 32'(out_valid), 32'd1);
      chk("t1.value", 32'(out_value), 32'd1234);
      chk("t1.bcd_frozen", 32'(entry_bcd), 32'h1234);
      tick(1);
      chk("t1.valid_drop", 32'(out_valid), 32'd0);
      chk("t1.bcd_clr",    32'(entry_bcd), 32'd0);
      chk("t1.count_clr",  32'(digit_count), 32'd0);
      chk("t1.busy_clr",   32'(busy), 32'd0);

      // 9,9,9,9,7: fifth digit ignored
      press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd7);
      chk("t2.count", 32'(digit_count), 32'd4);
      chk("t2.bcd",   32'(entry_bcd), 32'h9999);
      press(KEY_ENTER);
      tick(4);
      chk("t2.valid", 32'(out_valid), 32'd1);
      chk("t2.value", 32'(out_value), 32'd9999);
      tick(1);
      chk("t2.valid_drop", 32'(out_valid), 32'd0);

      // 13 ignored, 5,6,BKSP x3,8,ENTER
      press(4'd13);
      chk("t3.k13_count", 32'(digit_count), 32'd0);
      press(4'd5); press(4'd6);
      press(KEY_BKSP);
      chk("t3.bksp1_bcd",   32'(entry_bcd), 32'h5);
      chk("t3.bksp1_count", 32'(digit_count), 32'd1);
      press(KEY_BKSP);
      press(KEY_BKSP);
      chk("t3.bksp3_bcd",   32'(entry_bcd), 32'h0);
      chk("t3.bksp3_count", 32'(digit_count), 32'd0);
      press(4'd8);
      press(KEY_ENTER);
      tick(1);
      chk("t3.valid", 32'(out_valid), 32'd1);
      chk("t3.value", 32'(out_value), 32'd8);
      tick(1);
      press(KEY_ENTER);
      tick(3);
      chk("t3.empty_enter_valid", 32'(out_valid), 32'd0);
      chk("t3.empty_enter_busy",  32'(busy), 32'd0);

      // 4,2,ENTER held with ready low; keys during HOLD dropped
      out_ready = 1'b0;
      press(4'd4); press(4'd2);
      press(KEY_ENTER);
      tick(2);
      chk("t4.valid", 32'(out_valid), 32'd1);
      chk("t4.value", 32'(out_value), 32'd42);
      tick(5);
      press(4'd7);
      press(KEY_CLEAR);
      tick(13);
      chk("t4.hold_valid", 32'(out_valid), 32'd1);
      chk("t4.hold_value", 32'(out_value), 32'd42);
      chk("t4.hold_bcd",   32'(entry_bcd), 32'h42);
      chk("t4.hold_count", 32'(digit_count), 32'd2);
      chk("t4.hold_busy",  32'(busy), 32'd1);
      out_ready = 1'b1;
      tick(1);
      chk("t4.acc_valid", 32'(out_valid), 32'd0);
      chk("t4.acc_bcd",   32'(entry_bcd), 32'd0);

      // 3,1,4,ENTER then async reset in the second CONVERT cycle
      press(4'd3); press(4'd1); press(4'd4);
      press(KEY_ENTER);
      tick(1);
      nrst = 1'b0;
      #1;
      chk_idle("t5.rst");
      tick(2);
      nrst = 1'b1;
      tick(1);
      chk("t5.busy_after", 32'(busy), 32'd0);
      press(4'd7);
      press(KEY_ENTER);
      tick(1);
      chk("t5.valid", 32'(out_valid), 32'd1);
      chk("t5.value", 32'(out_value), 32'd7);
      tick(1);

      // Idle behaviour with a single digit held
      press(4'd6);
      tick(15);
      chk("t6.count_15", 32'(digit_count), 32'd1);
      tick(1);
`ifdef KEY_ENTRY_TIMEOUT_EN
      chk("t6.count_to", 32'(digit_count), 32'd0);
      chk("t6.bcd_to",   32'(entry_bcd), 32'd0);
`else
      tick(10);
      chk("t6.count_keep", 32'(digit_count), 32'd1);
      chk("t6.bcd_keep",   32'(entry_bcd), 32'h6);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
